uart_mmio: RTL and testbench

//  Memory-mapped 8N1 UART peripheral fed by the CPU MEM stage, alongside the LED/digit/Systick registers.

---
 rtl/uart_defs.sv | 53 +++++
 rtl/uart_rx_core.sv | 114 +++++++++++
 rtl/uart_mmio.sv | 187 ++++++++++++++++++
 tb/tb_uart_mmio.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/uart_defs.sv
// Shared definitions for the memory-mapped UART: register offsets,
// CON bit positions, FSM state encodings and the CON read-word packer.
package uart_defs;

    // Byte offsets from the peripheral base address
    localparam logic [31:0] OFF_TXD = 32'h0000_0000;
    localparam logic [31:0] OFF_RXD = 32'h0000_0004;
    localparam logic [31:0] OFF_CON = 32'h0000_0008;

    // CON register bit positions
    localparam int CON_TX_IE     = 0;
    localparam int CON_RX_IE     = 1;
    localparam int CON_TX_BUSY   = 2;
    localparam int CON_RX_VALID  = 3;
    localparam int CON_TX_DONE   = 4;
    localparam int CON_FRAME_ERR = 5;
    localparam int CON_OVERRUN   = 6;

    // TX FSM encodings
    localparam logic [1:0] TX_IDLE  = 2'd0;
    localparam logic [1:0] TX_START = 2'd1;
    localparam logic [1:0] TX_DATA  = 2'd2;
    localparam logic [1:0] TX_STOP  = 2'd3;

    // RX FSM encodings
    localparam logic [1:0] RX_IDLE  = 2'd0;
    localparam logic [1:0] RX_START = 2'd1;
    localparam logic [1:0] RX_DATA  = 2'd2;
    localparam logic [1:0] RX_STOP  = 2'd3;

    // Assemble the CON read word from the individual status/control bits
    function automatic logic [31:0] con_word(
        input logic tx_ie,
        input logic rx_ie,
        input logic tx_busy,
        input logic rx_valid,
        input logic tx_done,
        input logic frame_err,
        input logic overrun
    );
        logic [31:0] w;
        w                = '0;
        w[CON_TX_IE]     = tx_ie;
        w[CON_RX_IE]     = rx_ie;
        w[CON_TX_BUSY]   = tx_busy;
        w[CON_RX_VALID]  = rx_valid;
        w[CON_TX_DONE]   = tx_done;
        w[CON_FRAME_ERR] = frame_err;
        w[CON_OVERRUN]   = overrun;
        return w;
    endfunction

endpackage

// File: rtl/uart_rx_core.sv
// 8N1 receiver: two-flop synchronizer, falling-edge start detect with a
// mid-bit glitch check, then 8 data bits LSB first and a stop bit.
// Emits single-cycle pulses for a good byte or a framing error.
module uart_rx_core
    import uart_defs::*;
#(
    parameter int DIV = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       i_rx,
    output logic [7:0] o_byte,
    output logic       o_valid_pulse,
    output logic       o_frame_err_pulse
);

    localparam int             CW     = $clog2(DIV);
    localparam logic [CW-1:0]  C_LAST = CW'(DIV - 1);
    localparam logic [CW-1:0]  C_HALF = CW'(DIV / 2 - 1);
    localparam logic [CW-1:0]  C_ONE  = CW'(1);

    logic          r_s1, r_s2, r_s3;
    logic [1:0]    r_state;
    logic [CW-1:0] r_cnt;
    logic [2:0]    r_bit;
    logic [7:0]    r_shift;
    logic [7:0]    r_byte;
    logic          r_vld;
    logic          r_ferr;
    logic          w_fall;

    // r_s3 holds the previous synchronized level for edge detection
    assign w_fall = r_s3 & ~r_s2;

    // Synchronize the asynchronous line; idle level is high
    always_ff @(posedge clk) begin
        if (reset) begin
            r_s1 <= 1'b1;
            r_s2 <= 1'b1;
            r_s3 <= 1'b1;
        end else begin
            r_s1 <= i_rx;
            r_s2 <= r_s1;
            r_s3 <= r_s2;
        end
    end

    // Receive FSM: start check at half a bit, then sample every full bit
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= RX_IDLE;
            r_cnt   <= '0;
            r_bit   <= '0;
            r_shift <= '0;
            r_byte  <= '0;
            r_vld   <= 1'b0;
            r_ferr  <= 1'b0;
        end else begin
            r_vld  <= 1'b0;
            r_ferr <= 1'b0;
            case (r_state)
                RX_IDLE: begin
                    if (w_fall) begin
                        r_state <= RX_START;
                        r_cnt   <= '0;
                    end
                end
                RX_START: begin
                    if (r_cnt == C_HALF) begin
                        // A high sample mid-start means the low was a glitch
                        r_cnt   <= '0;
                        r_bit   <= '0;
                        r_state <= r_s2 ? RX_IDLE : RX_DATA;
                    end else begin
                        r_cnt <= r_cnt + C_ONE;
                    end
                end
                RX_DATA: begin
                    if (r_cnt == C_LAST) begin
                        r_cnt   <= '0;
                        r_shift <= {r_s2, r_shift[7:1]};
                        if (r_bit == 3'd7) begin
                            r_state <= RX_STOP;
                        end else begin
                            r_bit <= r_bit + 3'd1;
                        end
                    end else begin
                        r_cnt <= r_cnt + C_ONE;
                    end
                end
                RX_STOP: begin
                    if (r_cnt == C_LAST) begin
                        r_cnt   <= '0;
                        r_state <= RX_IDLE;
                        if (r_s2) begin
                            r_byte <= r_shift;
                            r_vld  <= 1'b1;
                        end else begin
                            r_ferr <= 1'b1;
                        end
                    end else begin
                        r_cnt <= r_cnt + C_ONE;
                    end
                end
                default: r_state <= RX_IDLE;
            endcase
        end
    end

    assign o_byte            = r_byte;
    assign o_valid_pulse     = r_vld;
    assign o_frame_err_pulse = r_ferr;

endmodule

// File: rtl/uart_mmio.sv
// Memory-mapped 8N1 UART on the MEM stage bus: TXD/RXD/CON decode,
// registered read data, TX FSM, sticky status flags and level irq.
module uart_mmio
    import uart_defs::*;
#(
    parameter logic [31:0] ADDR_BASE = 32'h4000_0018,
    parameter int          CLK_HZ    = 100_000_000,
    parameter int          BAUD      = 9600
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] addr,
    input  logic [31:0] wr_data,
    input  logic        mem_read,
    input  logic        mem_write,
    output logic [31:0] rd_data,
    input  logic        uart_rx,
    output logic        uart_tx,
    output logic        irq
);

    localparam int             DIV    = CLK_HZ / BAUD;
    localparam int             CW     = $clog2(DIV);
    localparam logic [CW-1:0]  C_LAST = CW'(DIV - 1);
    localparam logic [CW-1:0]  C_ONE  = CW'(1);
    localparam logic [31:0]    A_TXD  = ADDR_BASE + OFF_TXD;
    localparam logic [31:0]    A_RXD  = ADDR_BASE + OFF_RXD;
    localparam logic [31:0]    A_CON  = ADDR_BASE + OFF_CON;

    // Decode
    logic w_hit_txd, w_hit_rxd, w_hit_con;
    logic w_wr_txd, w_wr_con, w_rd, w_rd_rxd, w_rd_con;
    logic w_tx_busy, w_tx_fin;
    logic [31:0] w_con;
    logic w_unused;

    // Receiver outputs
    logic [7:0] w_rx_byte;
    logic       w_rx_vld;
    logic       w_rx_ferr;

    // TX state
    logic [1:0]    r_tx_state;
    logic [CW-1:0] r_tx_cnt;
    logic [2:0]    r_tx_bit;
    logic [7:0]    r_tx_shift;
    logic          r_tx;

    // Register file
    logic        r_tx_ie, r_rx_ie;
    logic        r_rx_valid, r_tx_done, r_frame_err, r_overrun;
    logic [7:0]  r_rx_byte;
    logic [31:0] r_rd_data;

    // Byte lane within the word is ignored, as are the upper store bits
    assign w_unused  = ^{addr[1:0], wr_data[31:8]};

    assign w_hit_txd = (addr[31:2] == A_TXD[31:2]);
    assign w_hit_rxd = (addr[31:2] == A_RXD[31:2]);
    assign w_hit_con = (addr[31:2] == A_CON[31:2]);

    // A store wins if the pipeline ever asserts both strobes
    assign w_wr_txd  = mem_write & w_hit_txd;
    assign w_wr_con  = mem_write & w_hit_con;
    assign w_rd      = mem_read & ~mem_write;
    assign w_rd_rxd  = w_rd & w_hit_rxd;
    assign w_rd_con  = w_rd & w_hit_con;

    assign w_tx_busy = (r_tx_state != TX_IDLE);
    assign w_tx_fin  = (r_tx_state == TX_STOP) && (r_tx_cnt == C_LAST);

    assign w_con = con_word(r_tx_ie, r_rx_ie, w_tx_busy, r_rx_valid,
                            r_tx_done, r_frame_err, r_overrun);

    uart_rx_core #(
        .DIV(DIV)
    ) u_rx (
        .clk              (clk),
        .reset            (reset),
        .i_rx             (uart_rx),
        .o_byte           (w_rx_byte),
        .o_valid_pulse    (w_rx_vld),
        .o_frame_err_pulse(w_rx_ferr)
    );

    // Transmit FSM: start bit, 8 data bits LSB first, stop bit, DIV clocks each
    always_ff @(posedge clk) begin
        if (reset) begin
            r_tx_state <= TX_IDLE;
            r_tx_cnt   <= '0;
            r_tx_bit   <= '0;
            r_tx_shift <= '0;
            r_tx       <= 1'b1;
        end else begin
            case (r_tx_state)
                TX_IDLE: begin
                    if (w_wr_txd) begin
                        r_tx_shift <= wr_data[7:0];
                        r_tx_cnt   <= '0;
                        r_tx_state <= TX_START;
                        r_tx       <= 1'b0;
                    end
                end
                TX_START: begin
                    if (r_tx_cnt == C_LAST) begin
                        r_tx_cnt   <= '0;
                        r_tx_bit   <= '0;
                        r_tx_state <= TX_DATA;
                        r_tx       <= r_tx_shift[0];
                        r_tx_shift <= {1'b0, r_tx_shift[7:1]};
                    end else begin
                        r_tx_cnt <= r_tx_cnt + C_ONE;
                    end
                end
                TX_DATA: begin
                    if (r_tx_cnt == C_LAST) begin
                        r_tx_cnt <= '0;
                        if (r_tx_bit == 3'd7) begin
                            r_tx_state <= TX_STOP;
                            r_tx       <= 1'b1;
                        end else begin
                            r_tx_bit   <= r_tx_bit + 3'd1;
                            r_tx       <= r_tx_shift[0];
                            r_tx_shift <= {1'b0, r_tx_shift[7:1]};
                        end
                    end else begin
                        r_tx_cnt <= r_tx_cnt + C_ONE;
                    end
                end
                TX_STOP: begin
                    if (r_tx_cnt == C_LAST) begin
                        r_tx_cnt   <= '0;
                        r_tx_state <= TX_IDLE;
                    end else begin
                        r_tx_cnt <= r_tx_cnt + C_ONE;
                    end
                end
                default: r_tx_state <= TX_IDLE;
            endcase
        end
    end

    // Control/status registers and registered read port; set events beat clears
    always_ff @(posedge clk) begin
        if (reset) begin
            r_tx_ie     <= 1'b0;
            r_rx_ie     <= 1'b0;
            r_rx_valid  <= 1'b0;
            r_tx_done   <= 1'b0;
            r_frame_err <= 1'b0;
            r_overrun   <= 1'b0;
            r_rx_byte   <= '0;
            r_rd_data   <= '0;
        end else begin
            if (w_wr_con) begin
                r_tx_ie <= wr_data[CON_TX_IE];
                r_rx_ie <= wr_data[CON_RX_IE];
            end

            if (w_tx_fin)      r_tx_done <= 1'b1;
            else if (w_rd_con) r_tx_done <= 1'b0;

            if (w_rx_ferr)     r_frame_err <= 1'b1;
            else if (w_rd_con) r_frame_err <= 1'b0;

            // An RXD read landing with the new byte consumes the old one: no overrun
            if (w_rx_vld && r_rx_valid && !w_rd_rxd) r_overrun <= 1'b1;
            else if (w_rd_con)                       r_overrun <= 1'b0;

            if (w_rx_vld) begin
                r_rx_valid <= 1'b1;
                r_rx_byte  <= w_rx_byte;
            end else if (w_rd_rxd) begin
                r_rx_valid <= 1'b0;
            end

            if (w_rd_rxd)      r_rd_data <= {24'b0, r_rx_byte};
            else if (w_rd_con) r_rd_data <= w_con;
            else               r_rd_data <= '0;
        end
    end

    assign rd_data = r_rd_data;
    assign uart_tx = r_tx;
    assign irq     = (r_tx_ie & r_tx_done) | (r_rx_ie & r_rx_valid);

endmodule

// File: tb/tb_uart_mmio.sv
// Directed bench for uart_mmio at DIV=16: register table, TX waveform,
// RX frames, overrun, framing error, glitch, dropped write, mid-frame reset.
module tb_uart_mmio;

    localparam logic [31:0] A_TXD = 32'h4000_0018;
    localparam logic [31:0] A_RXD = 32'h4000_001C;
    localparam logic [31:0] A_CON = 32'h4000_0020;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] addr;
    logic [31:0] wr_data;
    logic        mem_read;
    logic        mem_write;
    logic [31:0] rd_data;
    logic        uart_rx;
    logic        uart_tx;
    logic        irq;

    int n_tot = 0;
    int n_bad = 0;

    uart_mmio #(
        .ADDR_BASE(32'h4000_0018),
        .CLK_HZ   (16),
        .BAUD     (1)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .addr     (addr),
        .wr_data  (wr_data),
        .mem_read (mem_read),
        .mem_write(mem_write),
        .rd_data  (rd_data),
        .uart_rx  (uart_rx),
        .uart_tx  (uart_tx),
        .irq      (irq)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic        re;
        logic [31:0] a;
        logic [31:0] d;
        logic [31:0] exp_rd;
        logic        exp_irq;
    } vec_t;

    vec_t vt[19];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tot++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        addr = a; wr_data = d; mem_write = 1'b1;
        @(negedge clk);
        mem_write = 1'b0; addr = '0; wr_data = '0;
    endtask

    task automatic rdchk(input string nm, input logic [31:0] a, input logic [31:0] exp);
        addr = a; mem_read = 1'b1;
        @(negedge clk);
        mem_read = 1'b0; addr = '0;
        chk(nm, rd_data, exp);
    endtask

    task automatic send_rx(input logic [7:0] b, input logic stopb);
        logic [9:0] fr;
        fr = {stopb, b, 1'b0};
        for (int i = 0; i < 10; i++) begin
            uart_rx = fr[i];
            repeat (16) @(negedge clk);
        end
        uart_rx = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    // Watch 160 clocks of TX output starting just after the TXD write edge;
    // optionally inject a second TXD write at cycle inj_k, and probe busy mid-frame
    task automatic tx_watch(input string nm, input logic [7:0] b, input int inj_k,
                            input logic [7:0] inj_b);
        int   errs;
        logic exp_b;
        errs = 0;
        for (int k = 0; k < 160; k++) begin
            if (k < 16)       exp_b = 1'b0;
            else if (k < 144) exp_b = b[(k - 16) / 16];
            else              exp_b = 1'b1;
            if (uart_tx !== exp_b) errs++;
            if (k == 81) chk({nm, "_busy_mid"}, {31'b0, rd_data[2]}, 32'h1);
            mem_write = (k == inj_k);
            mem_read  = (k == 80);
            if (k == inj_k) begin
                addr = A_TXD; wr_data = {24'b0, inj_b};
            end else if (k == 80) begin
                addr = A_CON; wr_data = '0;
            end else begin
                addr = '0; wr_data = '0;
            end
            @(negedge clk);
        end
        mem_write = 1'b0; mem_read = 1'b0; addr = '0; wr_data = '0;
        chk({nm, "_wave"}, errs, 0);
    endtask

    initial begin
        int errs;

        reset = 1'b1; addr = '0; wr_data = '0;
        mem_read = 1'b0; mem_write = 1'b0; uart_rx = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("reset_tx", {31'b0, uart_tx}, 32'h1);
        chk("reset_rd", rd_data, 32'h0);
        chk("reset_irq", {31'b0, irq}, 32'h0);

        // Register access table: decode, CON write masking, misses, store-wins
        vt[0]  = '{1'b0, 1'b1, A_CON,        32'h0,        32'h0, 1'b0};
        vt[1]  = '{1'b0, 1'b1, A_RXD,        32'h0,        32'h0, 1'b0};
        vt[2]  = '{1'b0, 1'b1, A_TXD,        32'h0,        32'h0, 1'b0};
        vt[3]  = '{1'b1, 1'b0, A_CON,        32'hFFFF_FFFF, 32'h0, 1'b0};
        vt[4]  = '{1'b0, 1'b1, A_CON,        32'h0,        32'h3, 1'b0};
        vt[5]  = '{1'b0, 1'b1, 32'h4000_0023, 32'h0,       32'h3, 1'b0};
        vt[6]  = '{1'b1, 1'b0, 32'h4000_0021, 32'h1,       32'h0, 1'b0};
        vt[7]  = '{1'b0, 1'b1, A_CON,        32'h0,        32'h1, 1'b0};
        vt[8]  = '{1'b1, 1'b0, 32'h4000_0024, 32'hFFFF_FFFF, 32'h0, 1'b0};
        vt[9]  = '{1'b0, 1'b1, 32'h4000_0024, 32'h0,       32'h0, 1'b0};
        vt[10] = '{1'b1, 1'b0, 32'h0000_0020, 32'h3,       32'h0, 1'b0};
        vt[11] = '{1'b0, 1'b1, 32'h0000_0020, 32'h0,       32'h0, 1'b0};
        vt[12] = '{1'b0, 1'b1, A_CON,        32'h0,        32'h1, 1'b0};
        vt[13] = '{1'b1, 1'b0, 32'h0000_0018, 32'h55,      32'h0, 1'b0};
        vt[14] = '{1'b0, 1'b1, A_CON,        32'h0,        32'h1, 1'b0};
        vt[15] = '{1'b1, 1'b1, A_CON,        32'h2,        32'h0, 1'b0};
        vt[16] = '{1'b0, 1'b1, A_CON,        32'h0,        32'h2, 1'b0};
        vt[17] = '{1'b1, 1'b0, A_CON,        32'h0,        32'h0, 1'b0};
        vt[18] = '{1'b0, 1'b1, A_CON,        32'h0,        32'h0, 1'b0};
        for (int i = 0; i < 19; i++) begin
            mem_write = vt[i].we; mem_read = vt[i].re;
            addr = vt[i].a; wr_data = vt[i].d;
            @(negedge clk);
            mem_write = 1'b0; mem_read = 1'b0; addr = '0; wr_data = '0;
            chk($sformatf("vec%0d_rd", i), rd_data, vt[i].exp_rd);
            chk($sformatf("vec%0d_irq", i), {31'b0, irq}, {31'b0, vt[i].exp_irq});
        end

        // 1: transmit 0xA5 with tx_ie set
        wr(A_CON, 32'h1);
        wr(A_TXD, 32'hA5);
        chk("t1_irq_busy", {31'b0, irq}, 32'h0);
        tx_watch("t1", 8'hA5, -1, 8'h00);
        chk("t1_tx_idle", {31'b0, uart_tx}, 32'h1);
        chk("t1_irq_done", {31'b0, irq}, 32'h1);
        rdchk("t1_con", A_CON, 32'h11);
        chk("t1_irq_clr", {31'b0, irq}, 32'h0);

        // 2: receive 0x3C with rx_ie set
        wr(A_CON, 32'h2);
        send_rx(8'h3C, 1'b1);
        chk("t2_irq", {31'b0, irq}, 32'h1);
        rdchk("t2_con", A_CON, 32'h0A);
        rdchk("t2_rxd", A_RXD, 32'h3C);
        chk("t2_irq_clr", {31'b0, irq}, 32'h0);
        rdchk("t2_con2", A_CON, 32'h02);

        // 3: overrun
        send_rx(8'h81, 1'b1);
        send_rx(8'h7E, 1'b1);
        chk("t3_irq", {31'b0, irq}, 32'h1);
        rdchk("t3_con", A_CON, 32'h4A);
        rdchk("t3_con2", A_CON, 32'h0A);
        rdchk("t3_rxd", A_RXD, 32'h7E);
        rdchk("t3_con3", A_CON, 32'h02);

        // 4: framing error, then a short glitch, then a clean frame
        send_rx(8'h55, 1'b0);
        chk("t4_irq", {31'b0, irq}, 32'h0);
        rdchk("t4_con", A_CON, 32'h22);
        rdchk("t4_con2", A_CON, 32'h02);
        uart_rx = 1'b0;
        repeat (4) @(negedge clk);
        uart_rx = 1'b1;
        repeat (40) @(negedge clk);
        rdchk("t4_glitch_con", A_CON, 32'h02);
        chk("t4_glitch_irq", {31'b0, irq}, 32'h0);
        send_rx(8'hC3, 1'b1);
        rdchk("t4_rxd", A_RXD, 32'hC3);

        // 5a: second TXD write while busy is dropped
        wr(A_CON, 32'h1);
        wr(A_TXD, 32'h11);
        tx_watch("t5", 8'h11, 19, 8'h22);
        chk("t5_irq_done", {31'b0, irq}, 32'h1);
        errs = 0;
        for (int k = 0; k < 40; k++) begin
            if (uart_tx !== 1'b1) errs++;
            @(negedge clk);
        end
        chk("t5_no_second", errs, 0);
        rdchk("t5_con", A_CON, 32'h11);

        // 5b: reset 50 clocks into a frame
        wr(A_CON, 32'h3);
        wr(A_TXD, 32'h00);
        repeat (49) @(negedge clk);
        chk("t5_mid_low", {31'b0, uart_tx}, 32'h0);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("t5_rst_tx", {31'b0, uart_tx}, 32'h1);
        errs = 0;
        for (int k = 0; k < 32; k++) begin
            if (uart_tx !== 1'b1) errs++;
            @(negedge clk);
        end
        chk("t5_rst_idle", errs, 0);
        rdchk("t5_rst_con", A_CON, 32'h0);
        chk("t5_rst_irq", {31'b0, irq}, 32'h0);

        $display("test done: total=%0d bad=%0d", n_tot, n_bad);
        $finish;
    end

endmodule
